router_ingress: RTL and testbench
=================================

# router_ingress

Buffered ingress stage that sits directly upstream of the 4-port `simple_router`. It accepts words tagged with a 2-bit destination over a valid/ready handshake and stores them in a FIFO. It replays them to the router as single-cycle `din`/`din_en`/`addr` strobes, with optional downstream stall. Idle outputs are driven to zero, so the router's outputs stay zero between words.

## Interface
- `DATA_WIDTH`, 32, payload width.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `CNT_WIDTH`, 16, width of per-port statistics counters (used only with stats enabled).

- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_WIDTH  payload.
- `in_addr`  in  2  destination port 0..3.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  FIFO can accept.
- `flush`  in  1  synchronous FIFO clear.
- `out_stall`  in  1  hold; no word is popped while high.
- `out_din`  out  DATA_WIDTH  to router `din`.
- `out_din_en`  out  1  to router `din_en`.
- `out_addr`  out  2  to router `addr`.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy.
- `stat_cnt0..stat_cnt3`  out  CNT_WIDTH  words dispatched per port (stats build only).

## Operation
- Each FIFO entry stores {addr, data}. There is a write pointer, a read pointer, and an occupancy count.
- Push: `in_valid && in_ready && !flush`.
- `in_ready = (fifo_count != DEPTH)`. It is combinational from registered count only and does not depend on a same-cycle pop.
- Pop: `fifo_count != 0 && !out_stall && !flush`.
- On pop, the head entry is loaded into the output register and `out_din_en` is set to 1.
- On any other cycle, `out_din_en`, `out_din` and `out_addr` are all loaded with 0.
- Simultaneous push and pop leaves the count unchanged. Both pointers advance.
- Pointers wrap modulo DEPTH. The count saturates neither way, because the handshake prevents overflow and underflow.
- Flush has priority over push and pop. It zeroes the pointers, the count and the output register on the next edge. Statistics are not cleared.
- Order is strict FIFO across all destinations, with no reordering.

## Timing
- Reset (asynchronous, `resetn` low) clears the following:
  - `fifo_count`, the pointers and the stats are 0.
  - `out_din_en` is 0; `out_din` and `out_addr` are 0.
  - `in_ready` is 1 after reset, since the count is 0.
- Reset asserted mid-operation discards all stored words immediately.
- Latency: a word pushed at edge N into an empty FIFO pops at edge N+1. `out_din_en` is high for the cycle after edge N+1.
- Throughput is one word per cycle when unstalled.
- `out_stall` sampled high at edge N causes `out_din_en` to be 0 after edge N. The head entry is held.
- When full with a simultaneous pop, `in_ready` stays 0 that cycle. The freed slot is visible next cycle.
- FIFO storage needs no reset. The control registers and the output register are reset.

## Configuration
- `ROUTER_INGRESS_STATS_EN` defined:
  - Four CNT_WIDTH counters are built. `stat_cnt[k]` increments on each pop with addr == k.
  - The counters saturate at all-ones.
- Without the macro:
  - No counter flops are built.
  - The `stat_cnt*` ports remain and are tied to 0.

## Structure
- Package `router_pkg` holds the shared constants and types:
  - `ADDR_WIDTH = 2`, `NUM_PORTS = 4`, and the default `DATA_WIDTH = 32`.
  - typedef `port_addr_t`: `logic [ADDR_WIDTH-1:0]`.
  - typedef `route_word_t`: packed struct {`port_addr_t addr`; `logic [DATA_WIDTH-1:0] data`}.
- Sub-module `router_sync_fifo` (generic storage, pointers, count, full and empty flags) is instantiated once.
- The top level adds the output register, the stall/flush gating and the stats.

## Test plan
- Reset: hold `resetn` low and drive `in_valid` = 1. Required: `in_ready` = 1 and `out_din_en` = 0 throughout; `out_din`, `out_addr` and `fifo_count` = 0.
- Single word: push 0xA5A5A5A5 with addr 2 at edge N. Required: after edge N+1, `out_din_en` = 1, `out_din` = 0xA5A5A5A5, `out_addr` = 2. After edge N+2, all outputs = 0.
- Fill and backpressure:
  - Stimulus: hold `out_stall` = 1 and push 8 words 0..7 with addr = i%4.
  - Required while stalled: `fifo_count` = 8, `in_ready` = 0, and a 9th word is not accepted.
  - Then release the stall. Required: words 0..7 emerge in order on 8 consecutive cycles.
- Simultaneous push and pop:
  - Stimulus: streaming at count = 3 with push and pop every cycle.
  - Required: count stays 3 and the pointers wrap correctly over 20 words with no loss.
- Flush:
  - Stimulus: with 5 words queued, assert `flush` together with `in_valid`.
  - Required: the next cycle has `fifo_count` = 0 and `out_din_en` = 0, and the flushed-cycle word is not stored.
- Stats (macro defined):
  - Stimulus: dispatch 3 words to port 1 and 1 word to port 3.
  - Required: `stat_cnt1` = 3, `stat_cnt3` = 1, others 0.
  - Saturation: preload a count near all-ones. Required: the counter holds at all-ones.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and types for the router ingress path.
package router_pkg;
  localparam int ADDR_WIDTH = 2;
  localparam int NUM_PORTS  = 4;
  localparam int DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] port_addr_t;

  typedef struct packed {
    port_addr_t            addr;
    logic [DATA_WIDTH-1:0] data;
  } route_word_t;
endpackage

// File: rtl/router_sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers, occupancy, full/empty.
module router_sync_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
endmodule

// File: rtl/router_ingress.sv
// Buffered ingress ahead of simple_router: FIFO, single-cycle output strobes, stall/flush.
// Optional per-port dispatch counters are built when ROUTER_INGRESS_STATS_EN is defined.
module router_ingress
  import router_pkg::*;
#(
  parameter  int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter  int DEPTH      = 8,
  parameter  int CNT_WIDTH  = 16,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  out_stall,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_din_en,
  output logic [1:0]            out_addr,
  output logic [CNT_W-1:0]      fifo_count,
  output logic [CNT_WIDTH-1:0]  stat_cnt0,
  output logic [CNT_WIDTH-1:0]  stat_cnt1,
  output logic [CNT_WIDTH-1:0]  stat_cnt2,
  output logic [CNT_WIDTH-1:0]  stat_cnt3
);
  typedef struct packed {
    port_addr_t            addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t wr_entry, head;
  logic   push, pop, full, empty;

  logic [DATA_WIDTH-1:0] out_din_q, out_din_d;
  port_addr_t            out_addr_q, out_addr_d;
  logic                  out_en_q, out_en_d;

  // in_ready depends only on registered occupancy, never on a same-cycle pop
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !empty && !out_stall && !flush;

  assign wr_entry.addr = in_addr;
  assign wr_entry.data = in_data;

  router_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    out_din_d  = '0;
    out_addr_d = '0;
    out_en_d   = 1'b0;
    if (pop) begin
      out_din_d  = head.data;
      out_addr_d = head.addr;
      out_en_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_din_q  <= '0;
      out_addr_q <= '0;
      out_en_q   <= 1'b0;
    end else begin
      out_din_q  <= out_din_d;
      out_addr_q <= out_addr_d;
      out_en_q   <= out_en_d;
    end
  end

  assign out_din    = out_din_q;
  assign out_addr   = out_addr_q;
  assign out_din_en = out_en_q;

`ifdef ROUTER_INGRESS_STATS_EN
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturate at all-ones; flush leaves the counters alone
    always_comb begin
      cnt_d = cnt_q;
      if (pop && head.addr == port_addr_t'(gi) && cnt_q != {CNT_WIDTH{1'b1}})
        cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end
  end

  assign stat_cnt0 = g_stat[0].cnt_q;
  assign stat_cnt1 = g_stat[1].cnt_q;
  assign stat_cnt2 = g_stat[2].cnt_q;
  assign stat_cnt3 = g_stat[3].cnt_q;
`else
  assign stat_cnt0 = {CNT_WIDTH{1'b0}};
  assign stat_cnt1 = {CNT_WIDTH{1'b0}};
  assign stat_cnt2 = {CNT_WIDTH{1'b0}};
  assign stat_cnt3 = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_router_ingress.sv
// Randomized self-checking bench for router_ingress against a queue-based reference model.
module tb_router_ingress;
  import router_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CNTW  = $clog2(DEPTH) + 1;
  localparam int MAXC  = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            resetn;
  logic [DW-1:0]   in_data;
  logic [1:0]      in_addr;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic            out_stall;
  logic [DW-1:0]   out_din;
  logic            out_din_en;
  logic [1:0]      out_addr;
  logic [CNTW-1:0] fifo_count;
  logic [CW-1:0]   stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;

  router_ingress #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_stall  (out_stall),
    .out_din    (out_din),
    .out_din_en (out_din_en),
    .out_addr   (out_addr),
    .fifo_count (fifo_count),
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1),
    .stat_cnt2  (stat_cnt2),
    .stat_cnt3  (stat_cnt3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  route_word_t q[$];
  int          stat_m[4];
  logic        exp_en;
  logic [31:0] exp_din;
  logic [1:0]  exp_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int stat_exp(input int k);
`ifdef ROUTER_INGRESS_STATS_EN
    return stat_m[k];
`else
    return 0;
`endif
  endfunction

  function automatic int cexp(input int v);
`ifdef ROUTER_INGRESS_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 4; k++) stat_m[k] = 0;
    exp_en   = 1'b0;
    exp_din  = '0;
    exp_addr = '0;
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge
  task automatic step(input logic v, input logic [1:0] a, input logic [31:0] d,
                      input logic st, input logic fl);
    bit          ready_pre;
    route_word_t w;
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    out_stall = st;
    flush     = fl;
    #1;
    ready_pre = (q.size() != DEPTH);
    check("in_ready", in_ready, ready_pre);
    check("count_pre", fifo_count, q.size());
    @(posedge clk);
    exp_en   = 1'b0;
    exp_din  = '0;
    exp_addr = '0;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && !st) begin
        w        = q.pop_front();
        exp_en   = 1'b1;
        exp_din  = w.data;
        exp_addr = w.addr;
        if (stat_m[w.addr] < MAXC) stat_m[w.addr]++;
      end
      if (v && ready_pre) begin
        w.addr = a;
        w.data = d;
        q.push_back(w);
      end
    end
    #1;
    check("out_din_en", out_din_en, exp_en);
    check("out_din", out_din, exp_din);
    check("out_addr", out_addr, exp_addr);
    check("count_post", fifo_count, q.size());
    check("stat_cnt0", stat_cnt0, stat_exp(0));
    check("stat_cnt1", stat_cnt1, stat_exp(1));
    check("stat_cnt2", stat_cnt2, stat_exp(2));
    check("stat_cnt3", stat_cnt3, stat_exp(3));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_en", out_din_en, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 2'd3;
    in_data   = 32'hFFFF_FFFF;
    flush     = 1'b0;
    out_stall = 1'b0;
    model_reset();

    // Reset held with in_valid high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_din_en", out_din_en, 0);
      check("rst_din", out_din, 0);
      check("rst_addr", out_addr, 0);
      check("rst_fifo_count", fifo_count, 0);
    end
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(posedge clk);
    #1;

    // Single word
    step(1'b1, 2'd2, 32'hA5A5_A5A5, 1'b0, 1'b0);
    check("single_en_n", out_din_en, 0);
    idle(1);
    check("single_en", out_din_en, 1);
    check("single_din", out_din, 32'hA5A5_A5A5);
    check("single_addr", out_addr, 2);
    idle(1);
    check("single_idle_din", out_din, 0);

    // Fill under stall, rejected 9th word, then drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 2'(i % 4), 32'(i), 1'b1, 1'b0);
    check("full_count", fifo_count, 8);
    check("full_ready", in_ready, 0);
    step(1'b1, 2'd1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("full_9th", fifo_count, 8);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check("drain_din", out_din, 32'(i));
      check("drain_en", out_din_en, 1);
    end
    idle(1);

    // Streaming at count 3 with push and pop every cycle
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 32'h100 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b0, 1'b0);
      check("stream_count", fifo_count, 3);
    end
    idle(4);

    // Flush with a word offered in the same cycle
    for (int i = 0; i < 5; i++) step(1'b1, 2'(i % 4), 32'h200 + 32'(i), 1'b1, 1'b0);
    step(1'b1, 2'd1, 32'h0000_BEEF, 1'b0, 1'b1);
    check("flush_count", fifo_count, 0);
    check("flush_en", out_din_en, 0);
    idle(2);
    check("flush_nostore", out_din_en, 0);

    // Statistics from a clean reset
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 32'h300 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 2'd3, 32'h0000_0333, 1'b0, 1'b0);
    idle(3);
    check("stats_p0", stat_cnt0, cexp(0));
    check("stats_p1", stat_cnt1, cexp(3));
    check("stats_p2", stat_cnt2, cexp(0));
    check("stats_p3", stat_cnt3, cexp(1));

    // Random traffic; long enough for the narrow counters to saturate
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    idle(DEPTH + 1);
    check("sat_p0", stat_cnt0, cexp(MAXC));

    // Asynchronous reset mid-operation discards queued words
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), $urandom, 1'b1, 1'b0);
    in_valid = 1'b0;
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    check("async_count", fifo_count, 0);
    check("async_ready", in_ready, 1);
    check("async_stat1", stat_cnt1, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    check("async_empty_en", out_din_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
